// File: rtl/bcd_score_counter_pkg.sv
// Shared constants and helpers for the BCD score counter.
package bcd_score_counter_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT    = 4'd9;
    localparam logic [3:0]  STEP_CLAMP       = 4'd9;
    localparam int unsigned MAX_SCORE_DIGITS = 8;

    // Force any non-decimal nibble to 9 so stored digits stay valid BCD.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
    endfunction

endpackage

// File: rtl/bcd_score_counter_digit_addsub.sv
// One BCD digit adder/subtractor with decimal correction.
// cin/cout carry on add and borrow on subtract.
module bcd_score_counter_digit_addsub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [3:0] r,
    output logic       cout
);

    logic [4:0] sum;
    logic [4:0] diff;

    always_comb begin
        sum  = 5'(a) + 5'(b) + 5'(cin);
        diff = 5'(a) - 5'(b) - 5'(cin);
        r    = 4'd0;
        cout = 1'b0;
        if (sub) begin
            // A negative result wraps the 5-bit diff; adding 10 recovers the digit.
            if (diff[4]) begin
                r    = 4'(diff + 5'd10);
                cout = 1'b1;
            end else begin
                r    = diff[3:0];
            end
        end else begin
            if (sum > 5'd9) begin
                r    = 4'(sum - 5'd10);
                cout = 1'b1;
            end else begin
                r    = sum[3:0];
            end
        end
    end

endmodule

// File: rtl/bcd_score_counter.sv
// N-digit BCD score register: clear, load, inc/dec by a BCD step,
// wrap or saturate at the range limits, with registered ovf/unf pulses.
module bcd_score_counter
    import bcd_score_counter_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter bit          WRAP       = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
    input  logic                        inc,
    input  logic                        dec,
    input  logic [3:0]                  step,
    output logic [BCD_W*NUM_DIGITS-1:0] digits,
    output logic                        ovf,
    output logic                        unf,
    output logic                        is_zero,
    output logic                        is_max
);

    localparam int unsigned W         = BCD_W * NUM_DIGITS;
    localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{BCD_MAX_DIGIT}};

    logic [3:0]            step_eff;
    logic [NUM_DIGITS:0]   carry;
    logic [W-1:0]          arith;
    logic [W-1:0]          digits_nxt;
    logic                  ovf_nxt;
    logic                  unf_nxt;

    assign step_eff = (step > STEP_CLAMP) ? STEP_CLAMP : step;
    assign carry[0] = 1'b0;

    // Ripple chain: step enters at the units digit, upper digits see zero.
    for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_digit
        logic [3:0] b;
        if (g == 0) begin : g_units
            assign b = step_eff;
        end else begin : g_upper
            assign b = 4'd0;
        end

        bcd_score_counter_digit_addsub u_addsub (
            .a    (digits[g*BCD_W +: BCD_W]),
            .b    (b),
            .sub  (dec),
            .cin  (carry[g]),
            .r    (arith[g*BCD_W +: BCD_W]),
            .cout (carry[g+1])
        );
    end

    // Command priority: clr, then load, then exactly one of inc/dec.
    always_comb begin
        digits_nxt = digits;
        ovf_nxt    = 1'b0;
        unf_nxt    = 1'b0;
        if (clr) begin
            digits_nxt = '0;
        end else if (load) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                digits_nxt[k*BCD_W +: BCD_W] = clamp_digit(load_val[k*BCD_W +: BCD_W]);
            end
        end else if (inc ^ dec) begin
            if (carry[NUM_DIGITS]) begin
                ovf_nxt = inc;
                unf_nxt = dec;
                if (WRAP) begin
                    digits_nxt = arith;
                end else begin
                    digits_nxt = inc ? ALL_NINES : '0;
                end
            end else begin
                digits_nxt = arith;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            digits <= digits_nxt;
            ovf    <= ovf_nxt;
            unf    <= unf_nxt;
        end
    end

    assign is_zero = (digits == '0);
    assign is_max  = (digits == ALL_NINES);

endmodule

// File: tb/tb_bcd_score_counter.sv
// Randomized self-checking bench for bcd_score_counter against an integer model
// (instances: N=2 wrap, N=2 saturate, N=4 wrap).
module tb_bcd_score_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr [3];
    logic        load[3];
    logic        inc [3];
    logic        dec [3];
    logic [3:0]  step[3];
    logic [15:0] load_val[3];

    logic [7:0]  dig0;
    logic [7:0]  dig1;
    logic [15:0] dig2;
    logic [2:0]  ovf, unf, is_zero, is_max;

    int checks   = 0;
    int failures = 0;
    int mval[3];
    int nd[3]    = '{2, 2, 4};
    bit wr[3]    = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    bcd_score_counter #(.NUM_DIGITS(2), .WRAP(1'b1)) u_w2 (
        .clk(clk), .reset(reset), .clr(clr[0]), .load(load[0]), .load_val(load_val[0][7:0]),
        .inc(inc[0]), .dec(dec[0]), .step(step[0]), .digits(dig0),
        .ovf(ovf[0]), .unf(unf[0]), .is_zero(is_zero[0]), .is_max(is_max[0]));

    bcd_score_counter #(.NUM_DIGITS(2), .WRAP(1'b0)) u_s2 (
        .clk(clk), .reset(reset), .clr(clr[1]), .load(load[1]), .load_val(load_val[1][7:0]),
        .inc(inc[1]), .dec(dec[1]), .step(step[1]), .digits(dig1),
        .ovf(ovf[1]), .unf(unf[1]), .is_zero(is_zero[1]), .is_max(is_max[1]));

    bcd_score_counter #(.NUM_DIGITS(4), .WRAP(1'b1)) u_w4 (
        .clk(clk), .reset(reset), .clr(clr[2]), .load(load[2]), .load_val(load_val[2]),
        .inc(inc[2]), .dec(dec[2]), .step(step[2]), .digits(dig2),
        .ovf(ovf[2]), .unf(unf[2]), .is_zero(is_zero[2]), .is_max(is_max[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v, input int n);
        logic [15:0] r = '0;
        int t = v;
        for (int k = 0; k < n; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] get_dig(input int w);
        case (w)
            0:       return {8'd0, dig0};
            1:       return {8'd0, dig1};
            default: return dig2;
        endcase
    endfunction

    // Integer reference: value in 0..10^n-1, decimal arithmetic on plain ints.
    function automatic void model(input int n, input bit wrap, inout int v,
                                  input bit c, input bit l, input logic [15:0] lv,
                                  input bit i, input bit d, input logic [3:0] st,
                                  output bit o, output bit u);
        int modv = 10 ** n;
        int s    = (st > 9) ? 9 : int'(st);
        int t;
        int dg;
        o = 1'b0;
        u = 1'b0;
        if (c) begin
            v = 0;
        end else if (l) begin
            v = 0;
            for (int k = n - 1; k >= 0; k--) begin
                dg = int'(lv[4*k +: 4]);
                if (dg > 9) dg = 9;
                v = v * 10 + dg;
            end
        end else if (i && !d) begin
            t = v + s;
            if (t >= modv) begin
                o = 1'b1;
                v = wrap ? t - modv : modv - 1;
            end else begin
                v = t;
            end
        end else if (d && !i) begin
            t = v - s;
            if (t < 0) begin
                u = 1'b1;
                v = wrap ? t + modv : 0;
            end else begin
                v = t;
            end
        end
    endfunction

    task automatic cmd(input int w, input bit c, input bit l, input logic [15:0] lv,
                       input bit i, input bit d, input logic [3:0] st);
        bit eo, eu;
        clr[w] = c; load[w] = l; load_val[w] = lv; inc[w] = i; dec[w] = d; step[w] = st;
        @(posedge clk);
        #1;
        clr[w] = 1'b0; load[w] = 1'b0; inc[w] = 1'b0; dec[w] = 1'b0; step[w] = 4'd0;
        model(nd[w], wr[w], mval[w], c, l, lv, i, d, st, eo, eu);
        check_val($sformatf("u%0d digits", w), 32'(get_dig(w)), 32'(to_bcd(mval[w], nd[w])));
        check_val($sformatf("u%0d ovf", w), 32'(ovf[w]), 32'(eo));
        check_val($sformatf("u%0d unf", w), 32'(unf[w]), 32'(eu));
        check_val($sformatf("u%0d is_zero", w), 32'(is_zero[w]), 32'(mval[w] == 0));
        check_val($sformatf("u%0d is_max", w), 32'(is_max[w]), 32'(mval[w] == 10 ** nd[w] - 1));
    endtask

    task automatic load_v(input int w, input int v);
        cmd(w, 1'b0, 1'b1, to_bcd(v, nd[w]), 1'b0, 1'b0, 4'd0);
    endtask

    task automatic idle(input int w);
        cmd(w, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b0; load[k] = 1'b0; inc[k] = 1'b0; dec[k] = 1'b0;
            step[k] = 4'd0; load_val[k] = 16'd0; mval[k] = 0;
        end
        reset = 1'b1;
        #12;
        check_val("rst digits", 32'(dig0), 32'h0);
        check_val("rst is_zero", 32'(is_zero), 32'h7);
        check_val("rst is_max", 32'(is_max), 32'h0);
        check_val("rst ovf_unf", 32'({ovf, unf}), 32'h0);
        reset = 1'b0;

        // Asynchronous reset mid-count at 42
        load_v(0, 42);
        #1 reset = 1'b1;
        #1;
        check_val("async digits", 32'(dig0), 32'h0);
        check_val("async is_zero", 32'(is_zero[0]), 32'h1);
        check_val("async pulses", 32'({ovf[0], unf[0]}), 32'h0);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) mval[k] = 0;

        load_v(0, 57);
        cmd(0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0);
        check_val("clr 57", 32'(dig0), 32'h00);

        load_v(0, 95);
        cmd(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 4'd7);
        check_val("95+7", 32'({ovf[0], dig0}), 32'h102);
        idle(0);
        load_v(0, 9);
        cmd(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 4'd1);
        check_val("09+1", 32'({ovf[0], dig0}), 32'h010);

        load_v(0, 1);
        cmd(0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 4'd3);
        check_val("01-3", 32'({unf[0], dig0}), 32'h198);
        load_v(0, 20);
        cmd(0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 4'd1);
        check_val("20-1", 32'({unf[0], dig0}), 32'h019);

        load_v(1, 97);
        cmd(1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 4'd5);
        check_val("sat 97+5", 32'({ovf[1], is_max[1], dig1}), 32'h399);
        cmd(1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 4'd1);
        check_val("sat 99+1", 32'({ovf[1], dig1}), 32'h199);
        load_v(1, 2);
        cmd(1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 4'd9);
        check_val("sat 02-9", 32'({unf[1], dig1}), 32'h100);

        load_v(0, 33);
        cmd(0, 1'b1, 1'b1, 16'h0044, 1'b1, 1'b0, 4'd1);
        check_val("prio clr", 32'(dig0), 32'h00);
        cmd(0, 1'b0, 1'b1, 16'h00A3, 1'b0, 1'b0, 4'd0);
        check_val("load A3", 32'(dig0), 32'h93);
        load_v(0, 50);
        cmd(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 4'd4);
        check_val("inc+dec", 32'({ovf[0], unf[0], dig0}), 32'h050);
        load_v(0, 10);
        cmd(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 4'd12);
        check_val("step 12", 32'(dig0), 32'h19);

        load_v(2, 9999);
        cmd(2, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 4'd1);
        check_val("9999+1", 32'({ovf[2], dig2}), 32'h10000);
        cmd(2, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 4'd1);
        check_val("0000-1", 32'({unf[2], dig2}), 32'h19999);

        // Random command stream across all three configurations
        for (int n = 0; n < 1500; n++) begin
            int w = (n < 600) ? 2 : int'($urandom_range(0, 2));
            int r = int'($urandom_range(0, 99));
            cmd(w, r < 2, (r >= 2) && (r < 7), 16'($urandom),
                1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
